// File: rtl/rv32i_pkg.sv
// Package shared by the RV32I memory-access stage.
// Holds the opcode and funct3 encodings the stage decodes, the FSM state type,
// and small helpers that map an access size and address onto byte lanes.
package rv32i_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, WAIT} mem_state_t;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_t;

  // funct3[1:0] carries the size for both loads and stores; the
  // undefined encodings fall through to a word access.
  function automatic acc_size_t acc_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input acc_size_t sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: return 4'b0001 << a;
      SZ_HALF: return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data is replicated into every lane so the byte enables alone
  // select which lane the memory actually writes.
  function automatic logic [31:0] lane_wdata(input acc_size_t sz, input logic [31:0] b);
    case (sz)
      SZ_BYTE: return {4{b[7:0]}};
      SZ_HALF: return {2{b[15:0]}};
      default: return b;
    endcase
  endfunction

  function automatic logic is_misaligned(input acc_size_t sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory-access stage (master) and memory (slave).
//  mem_req    request, held until mem_ack
//  mem_we     1 = store
//  mem_addr   word-aligned address
//  mem_be     byte enables
//  mem_wdata  lane-replicated store data
//  mem_rdata  read data, valid with mem_ack
//  mem_ack    completes the access in that cycle
interface mem_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// load_align: combinational load-data alignment and extension.
//  rdata   in  32  raw word from memory
//  a       in  2   low address bits of the access
//  funct3  in  3   load size/sign (LB/LH/LW/LBU/LHU; others pass the word)
//  data    out 32  aligned, sign- or zero-extended result
module load_align
  import rv32i_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  a,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (a)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
  end

  // Half-word lane is chosen by a[1] only; a[0] is don't-care here.
  assign half_v = a[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    case (funct3)
      F3_B:    data = {{24{byte_v[7]}}, byte_v};
      F3_BU:   data = {24'h0, byte_v};
      F3_H:    data = {{16{half_v[15]}}, half_v};
      F3_HU:   data = {16'h0, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage between EX and WB.
// Non-memory instructions pass to the MEM/WB registers in one cycle. Loads and
// stores latch their bus request, wait in WAIT for mem_ack (stalling EX), then
// deliver the aligned load data (0 for stores) to WB. An unanswered access is
// abandoned after ACK_TIMEOUT WAIT cycles with a bus_err pulse.
// Optional feature macro: MEM_MISALIGN_CHECK_EN -- misaligned half/word
// accesses skip the bus, take the 1-cycle path with wb_d=0 and pulse misalign.
// Ports:
//  clk, rst_n                  clock, asynchronous active-low reset
//  in_valid/opcode/funct3/c/b/pc  instruction from EX (c = address, b = store data)
//  stall                       EX must hold; in_valid ignored while high
//  bus                         data-memory bus (master side)
//  wb_valid/opcode/c/d/pc      MEM/WB boundary registers
//  bus_err                     one-cycle pulse on ack timeout
//  misalign                    one-cycle pulse on misaligned access
module mem_stage
  import rv32i_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [6:0]         in_opcode,
  input  logic [2:0]         in_funct3,
  input  logic [31:0]        in_c,
  input  logic [31:0]        in_b,
  input  logic [31:0]        in_pc,
  output logic               stall,
  mem_stage_if.master        bus,
  output logic               wb_valid,
  output logic [6:0]         wb_opcode,
  output logic [31:0]        wb_c,
  output logic [31:0]        wb_d,
  output logic [31:0]        wb_pc,
  output logic               bus_err,
  output logic               misalign
);

  localparam int CNT_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int TO_LAST = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;

  mem_state_t       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;

  logic      is_load, is_store, is_mem, mis_hit, issue, timeout_hit;
  acc_size_t in_size;

  // Request and pipeline fields captured when the access is issued.
  logic [31:2] addr_q;
  logic [1:0]  a_lo_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [6:0]  opcode_q;
  logic [31:0] c_q;
  logic [31:0] pc_q;

  logic        wb_valid_d, bus_err_d;
  logic [6:0]  wb_opcode_d;
  logic [31:0] wb_c_d, wb_d_d, wb_pc_d;
  logic [31:0] load_data;

  assign is_load  = (in_opcode == OPC_LOAD);
  assign is_store = (in_opcode == OPC_STORE);
  assign is_mem   = is_load || is_store;
  assign in_size  = acc_size(in_funct3);

`ifdef MEM_MISALIGN_CHECK_EN
  assign mis_hit = is_mem && is_misaligned(in_size, in_c[1:0]);
`else
  assign mis_hit = 1'b0;
`endif

  // The final allowed WAIT cycle is the one where the counter equals
  // ACK_TIMEOUT-1; ACK_TIMEOUT=0 never times out.
  assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt == CNT_W'(TO_LAST));

  load_align u_load_align (
    .rdata  (bus.mem_rdata),
    .a      (a_lo_q),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  // Request and stall are decoded from state so an asynchronous reset
  // drops them immediately.
  assign bus.mem_req   = (state == WAIT);
  assign stall         = (state == WAIT);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = {addr_q, 2'b00};
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    issue       = 1'b0;
    wb_valid_d  = 1'b0;
    wb_opcode_d = '0;
    wb_c_d      = '0;
    wb_d_d      = '0;
    wb_pc_d     = '0;
    bus_err_d   = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (in_valid) begin
          if (is_mem && !mis_hit) begin
            issue   = 1'b1;
            state_d = WAIT;
          end else begin
            wb_valid_d  = 1'b1;
            wb_opcode_d = in_opcode;
            wb_c_d      = in_c;
            wb_pc_d     = in_pc;
          end
        end
      end
      WAIT: begin
        if (bus.mem_ack || timeout_hit) begin
          state_d     = IDLE;
          cnt_d       = '0;
          wb_valid_d  = 1'b1;
          wb_opcode_d = opcode_q;
          wb_c_d      = c_q;
          wb_pc_d     = pc_q;
          // An ack arriving on the timeout cycle still completes the access.
          if (bus.mem_ack) begin
            if (!we_q) wb_d_d = load_data;
          end else begin
            bus_err_d = 1'b1;
          end
        end else if (ACK_TIMEOUT != 0) begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      addr_q    <= '0;
      a_lo_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      funct3_q  <= '0;
      opcode_q  <= '0;
      c_q       <= '0;
      pc_q      <= '0;
      wb_valid  <= 1'b0;
      wb_opcode <= '0;
      wb_c      <= '0;
      wb_d      <= '0;
      wb_pc     <= '0;
      bus_err   <= 1'b0;
    end else begin
      cnt <= cnt_d;
      if (issue) begin
        addr_q   <= in_c[31:2];
        a_lo_q   <= in_c[1:0];
        be_q     <= is_store ? lane_be(in_size, in_c[1:0]) : 4'b1111;
        wdata_q  <= is_store ? lane_wdata(in_size, in_b) : 32'h0;
        we_q     <= is_store;
        funct3_q <= in_funct3;
        opcode_q <= in_opcode;
        c_q      <= in_c;
        pc_q     <= in_pc;
      end
      wb_valid  <= wb_valid_d;
      wb_opcode <= wb_opcode_d;
      wb_c      <= wb_c_d;
      wb_d      <= wb_d_d;
      wb_pc     <= wb_pc_d;
      bus_err   <= bus_err_d;
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign <= 1'b0;
    else        misalign <= (state == IDLE) && in_valid && mis_hit;
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (ACK_TIMEOUT=4). The bench plays the memory:
// it raises mem_ack/mem_rdata by hand after a chosen number of wait cycles.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_mem_stage;

  localparam logic [6:0] OP_ADD   = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [31:0] in_c, in_b, in_pc;
  logic        stall, wb_valid, bus_err, misalign;
  logic [6:0]  wb_opcode;
  logic [31:0] wb_c, wb_d, wb_pc;

  int n_cmp = 0;
  int n_bad = 0;
  bit req_seen;

  // Values captured in the first WAIT cycle and the stall count of an access.
  logic        cap_req, cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  int          stall_cnt;

  mem_stage_if bus ();

  mem_stage #(.ACK_TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_opcode (in_opcode),
    .in_funct3 (in_funct3),
    .in_c      (in_c),
    .in_b      (in_b),
    .in_pc     (in_pc),
    .stall     (stall),
    .bus       (bus),
    .wb_valid  (wb_valid),
    .wb_opcode (wb_opcode),
    .wb_c      (wb_c),
    .wb_d      (wb_d),
    .wb_pc     (wb_pc),
    .bus_err   (bus_err),
    .misalign  (misalign)
  );

  always #5 clk = ~clk;

  always @(posedge bus.mem_req) req_seen = 1'b1;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] c, input logic [31:0] b, input logic [31:0] pc);
    in_valid  = v;
    in_opcode = op;
    in_funct3 = f3;
    in_c      = c;
    in_b      = b;
    in_pc     = pc;
  endtask

  // Issue one load/store, answer it after `waits` empty WAIT cycles.
  task automatic do_access(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] c,
                           input logic [31:0] b, input logic [31:0] pc, input int waits,
                           input logic [31:0] rdata);
    drive(1'b1, op, f3, c, b, pc);
    tick();
    drive(1'b0, 7'h0, 3'h0, 32'h0, 32'h0, 32'h0);
    cap_req   = bus.mem_req;
    cap_we    = bus.mem_we;
    cap_addr  = bus.mem_addr;
    cap_be    = bus.mem_be;
    cap_wdata = bus.mem_wdata;
    stall_cnt = 0;
    for (int i = 0; i < waits; i++) begin
      if (stall) stall_cnt++;
      tick();
    end
    bus.mem_rdata = rdata;
    bus.mem_ack   = 1'b1;
    if (stall) stall_cnt++;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    n_cmp++; if ({stall, bus.mem_req, bus.mem_we, wb_valid, bus_err, misalign} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 000000", {stall, bus.mem_req, bus.mem_we, wb_valid, bus_err, misalign}); end
    n_cmp++; if ({wb_opcode, wb_c, wb_d, wb_pc} !== 103'h0) begin
      n_bad++; $display("FAIL reset_wb: got %h want 0", {wb_opcode, wb_c, wb_d, wb_pc}); end
    n_cmp++; if ({bus.mem_addr, bus.mem_be, bus.mem_wdata} !== 68'h0) begin
      n_bad++; $display("FAIL reset_bus: got %h want 0", {bus.mem_addr, bus.mem_be, bus.mem_wdata}); end
  endtask

  task automatic test_alu();
    req_seen = 1'b0;
    drive(1'b1, OP_ADD, 3'h0, 32'h1234, 32'h9999, 32'h100);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL alu_stall: got %b want 0", stall); end
    tick();
    drive(1'b0, 7'h0, 3'h0, 32'h0, 32'h0, 32'h0);
    n_cmp++; if ({wb_valid, wb_opcode} !== {1'b1, OP_ADD}) begin
      n_bad++; $display("FAIL alu_valid_op: got %h want %h", {wb_valid, wb_opcode}, {1'b1, OP_ADD}); end
    n_cmp++; if ({wb_c, wb_d, wb_pc} !== {32'h1234, 32'h0, 32'h100}) begin
      n_bad++; $display("FAIL alu_data: got %h want %h", {wb_c, wb_d, wb_pc}, {32'h1234, 32'h0, 32'h100}); end
    tick();
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL alu_bubble: got %b want 0", wb_valid); end
    n_cmp++; if (req_seen !== 1'b0) begin n_bad++; $display("FAIL alu_no_req: got %b want 0", req_seen); end
  endtask

  task automatic test_load();
    do_access(OP_LOAD, 3'b000, 32'h203, 32'h0, 32'h200, 2, 32'h80FF_FF7F);
    n_cmp++; if ({cap_req, cap_we, cap_addr, cap_be} !== {1'b1, 1'b0, 32'h200, 4'hF}) begin
      n_bad++; $display("FAIL lb_bus: got %h want %h", {cap_req, cap_we, cap_addr, cap_be}, {1'b1, 1'b0, 32'h200, 4'hF}); end
    n_cmp++; if (stall_cnt != 3) begin n_bad++; $display("FAIL lb_stall_cycles: got %0d want 3", stall_cnt); end
    n_cmp++; if ({stall, wb_valid, wb_d, wb_c} !== {1'b0, 1'b1, 32'hFFFF_FF80, 32'h203}) begin
      n_bad++; $display("FAIL lb_wb: got %h want %h", {stall, wb_valid, wb_d, wb_c}, {1'b0, 1'b1, 32'hFFFF_FF80, 32'h203}); end
    do_access(OP_LOAD, 3'b100, 32'h203, 32'h0, 32'h204, 0, 32'h80FF_FF7F);
    n_cmp++; if (stall_cnt != 1) begin n_bad++; $display("FAIL lbu_stall_cycles: got %0d want 1", stall_cnt); end
    n_cmp++; if ({wb_valid, wb_d} !== {1'b1, 32'h0000_0080}) begin
      n_bad++; $display("FAIL lbu_wb_d: got %h want %h", {wb_valid, wb_d}, {1'b1, 32'h0000_0080}); end
    do_access(OP_LOAD, 3'b001, 32'h202, 32'h0, 32'h208, 1, 32'h80FF_FF7F);
    n_cmp++; if (wb_d !== 32'hFFFF_80FF) begin n_bad++; $display("FAIL lh_wb_d: got %h want ffff80ff", wb_d); end
    do_access(OP_LOAD, 3'b101, 32'h202, 32'h0, 32'h20C, 0, 32'h80FF_FF7F);
    n_cmp++; if (wb_d !== 32'h0000_80FF) begin n_bad++; $display("FAIL lhu_wb_d: got %h want 000080ff", wb_d); end
    do_access(OP_LOAD, 3'b010, 32'h208, 32'h0, 32'h210, 0, 32'h1357_9BDF);
    n_cmp++; if (wb_d !== 32'h1357_9BDF) begin n_bad++; $display("FAIL lw_wb_d: got %h want 13579bdf", wb_d); end
  endtask

  task automatic test_store();
    do_access(OP_STORE, 3'b001, 32'h202, 32'hDEAD_BEEF, 32'h300, 1, 32'hFFFF_FFFF);
    n_cmp++; if ({cap_we, cap_addr, cap_be, cap_wdata} !== {1'b1, 32'h200, 4'b1100, 32'hBEEF_BEEF}) begin
      n_bad++; $display("FAIL sh_bus: got %h want %h", {cap_we, cap_addr, cap_be, cap_wdata}, {1'b1, 32'h200, 4'b1100, 32'hBEEF_BEEF}); end
    n_cmp++; if ({wb_valid, wb_opcode, wb_d} !== {1'b1, OP_STORE, 32'h0}) begin
      n_bad++; $display("FAIL sh_wb: got %h want %h", {wb_valid, wb_opcode, wb_d}, {1'b1, OP_STORE, 32'h0}); end
    do_access(OP_STORE, 3'b000, 32'h201, 32'h1234_56A5, 32'h304, 0, 32'h0);
    n_cmp++; if ({cap_be, cap_wdata} !== {4'b0010, 32'hA5A5_A5A5}) begin
      n_bad++; $display("FAIL sb_bus: got %h want %h", {cap_be, cap_wdata}, {4'b0010, 32'hA5A5_A5A5}); end
    do_access(OP_STORE, 3'b010, 32'h300, 32'hCAFE_F00D, 32'h308, 0, 32'h0);
    n_cmp++; if ({cap_addr, cap_be, cap_wdata} !== {32'h300, 4'hF, 32'hCAFE_F00D}) begin
      n_bad++; $display("FAIL sw_bus: got %h want %h", {cap_addr, cap_be, cap_wdata}, {32'h300, 4'hF, 32'hCAFE_F00D}); end
  endtask

  task automatic test_timeout();
    drive(1'b1, OP_LOAD, 3'b010, 32'h400, 32'h0, 32'h400);
    tick();
    drive(1'b0, 7'h0, 3'h0, 32'h0, 32'h0, 32'h0);
    stall_cnt = 0;
    for (int i = 0; i < 20 && stall; i++) begin
      n_cmp++; if (bus_err !== 1'b0) begin n_bad++; $display("FAIL to_early_err: got %b want 0", bus_err); end
      stall_cnt++;
      tick();
    end
    n_cmp++; if (stall_cnt != 4) begin n_bad++; $display("FAIL to_wait_cycles: got %0d want 4", stall_cnt); end
    n_cmp++; if ({stall, bus_err, wb_valid, wb_d, wb_c} !== {1'b0, 1'b1, 1'b1, 32'h0, 32'h400}) begin
      n_bad++; $display("FAIL to_result: got %h want %h", {stall, bus_err, wb_valid, wb_d, wb_c}, {1'b0, 1'b1, 1'b1, 32'h0, 32'h400}); end
    tick();
    n_cmp++; if ({bus_err, wb_valid} !== 2'b00) begin
      n_bad++; $display("FAIL to_pulse: got %b want 00", {bus_err, wb_valid}); end
    // Ack on the last allowed WAIT cycle completes normally.
    do_access(OP_LOAD, 3'b010, 32'h500, 32'h0, 32'h500, 3, 32'h1234_5678);
    n_cmp++; if ({bus_err, wb_valid, wb_d} !== {1'b0, 1'b1, 32'h1234_5678}) begin
      n_bad++; $display("FAIL to_ack_wins: got %h want %h", {bus_err, wb_valid, wb_d}, {1'b0, 1'b1, 32'h1234_5678}); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, OP_LOAD, 3'b010, 32'h600, 32'h0, 32'h600);
    tick();
    drive(1'b0, 7'h0, 3'h0, 32'h0, 32'h0, 32'h0);
    n_cmp++; if (bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL rst_mid_pre_req: got %b want 1", bus.mem_req); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.mem_req, stall, wb_valid} !== 3'b000) begin
      n_bad++; $display("FAIL rst_mid_async: got %b want 000", {bus.mem_req, stall, wb_valid}); end
    #3 rst_n = 1'b1;
    tick();
    n_cmp++; if ({wb_valid, stall} !== 2'b00) begin
      n_bad++; $display("FAIL rst_mid_no_wb: got %b want 00", {wb_valid, stall}); end
    drive(1'b1, OP_ADD, 3'h0, 32'h55, 32'h0, 32'h604);
    tick();
    drive(1'b0, 7'h0, 3'h0, 32'h0, 32'h0, 32'h0);
    n_cmp++; if ({wb_valid, wb_c, wb_pc} !== {1'b1, 32'h55, 32'h604}) begin
      n_bad++; $display("FAIL rst_mid_add: got %h want %h", {wb_valid, wb_c, wb_pc}, {1'b1, 32'h55, 32'h604}); end
    tick();
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_CHECK_EN
    req_seen = 1'b0;
    drive(1'b1, OP_LOAD, 3'b010, 32'h101, 32'h0, 32'h700);
    tick();
    drive(1'b0, 7'h0, 3'h0, 32'h0, 32'h0, 32'h0);
    n_cmp++; if ({req_seen, misalign, wb_valid, wb_d} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
      n_bad++; $display("FAIL mis_lw: got %h want %h", {req_seen, misalign, wb_valid, wb_d}, {1'b0, 1'b1, 1'b1, 32'h0}); end
    tick();
    n_cmp++; if (misalign !== 1'b0) begin n_bad++; $display("FAIL mis_pulse: got %b want 0", misalign); end
`else
    do_access(OP_LOAD, 3'b010, 32'h101, 32'h0, 32'h700, 0, 32'hA1B2_C3D4);
    n_cmp++; if ({cap_req, cap_addr, cap_be} !== {1'b1, 32'h100, 4'hF}) begin
      n_bad++; $display("FAIL mis_off_bus: got %h want %h", {cap_req, cap_addr, cap_be}, {1'b1, 32'h100, 4'hF}); end
    n_cmp++; if ({misalign, wb_valid, wb_d} !== {1'b0, 1'b1, 32'hA1B2_C3D4}) begin
      n_bad++; $display("FAIL mis_off_wb: got %h want %h", {misalign, wb_valid, wb_d}, {1'b0, 1'b1, 32'hA1B2_C3D4}); end
`endif
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    drive(1'b0, 7'h0, 3'h0, 32'h0, 32'h0, 32'h0);
    #1;
    test_reset();
    #21 rst_n = 1'b1;
    test_alu();
    test_load();
    test_store();
    test_timeout();
    test_reset_mid();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
